// File: rtl/stream_demux.sv
// Registered 1-to-N stream demultiplexer: one-entry holding register steered to a
// selected output lane; beats addressed to a nonexistent lane are dropped and counted.
module stream_demux #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int SEL_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0] in_sel,
  output logic [N-1:0]     out_valid,
  input  logic [N-1:0]     out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             drop,
  output logic [7:0]       drop_count
);

  logic             full_q, full_d;
  logic [SEL_W-1:0] dest_q, dest_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             drop_q, drop_d;
  logic [7:0]       drop_count_q, drop_count_d;
  logic             pop, accept, legal;

  always_comb begin
    pop = 1'b0;
    // Loop rather than out_ready[dest_q]: dest_q can encode indices >= N.
    for (int unsigned i = 0; i < N; i++) begin
      if (dest_q == SEL_W'(i)) pop = full_q & out_ready[i];
    end
    in_ready = rst_n & (~full_q | pop);
    accept   = in_valid & in_ready;
    legal    = (32'(in_sel) < 32'(N));

    full_d       = full_q & ~pop;
    dest_d       = dest_q;
    data_d       = data_q;
    drop_d       = 1'b0;
    drop_count_d = drop_count_q;
    if (accept) begin
      if (legal) begin
        full_d = 1'b1;
        dest_d = in_sel;
        data_d = in_data;
      end else begin
        drop_d = 1'b1;
        if (drop_count_q != 8'hFF) drop_count_d = drop_count_q + 8'd1;
      end
    end
  end

  always_comb begin
    out_valid = '0;
    for (int unsigned i = 0; i < N; i++) begin
      out_valid[i] = full_q & (dest_q == SEL_W'(i));
    end
  end

  assign out_data   = data_q;
  assign drop       = drop_q;
  assign drop_count = drop_count_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full_q       <= 1'b0;
      dest_q       <= '0;
      data_q       <= '0;
      drop_q       <= 1'b0;
      drop_count_q <= '0;
    end else begin
      full_q       <= full_d;
      dest_q       <= dest_d;
      data_q       <= data_d;
      drop_q       <= drop_d;
      drop_count_q <= drop_count_d;
    end
  end

endmodule
